ter_inv_stream: RTL and testbench
=================================

// Module: ter_inv_stream
// PURPOSE
//  Streaming, parametrised ternary inverter for binary-encoded-ternary (BET) buses: N trits plus BW binary lanes.
//  Per-word mode selects STI/PTI/NTI/pass. Results are buffered in a DEPTH-entry FIFO behind valid/ready handshakes.
//  Invalid trit codes are flagged per word and counted.
//  Sits between mixed-radix logic stages as the pipelined successor of the single-trit combinational inverter.
// PARAMETERS
//  N      4  number of trits; in/out trit bus is 2*N bits, trit i at [2i+1:2i]
//  BW     1  number of binary lanes (>=1)
//  DEPTH  4  FIFO entries, power of 2, >=2
//  CNT_W  8  width of saturating error counter
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      input word valid
//  in_ready   out  1      block can accept word (= !full && !rst)
//  in_trit    in   2*N    BET trits: 2'b01=0(low), 2'b11=1(mid), 2'b10=2(high), 2'b00=invalid
//  in_bin     in   BW     binary lanes
//  in_mode    in   2      0=STI 1=PTI 2=NTI 3=PASS, sampled with the word
//  out_valid  out  1      FIFO head valid (= !empty)
//  out_ready  in   1      consumer accepts head
//  out_trit   out  2*N    transformed trits of head word
//  out_bin    out  BW     transformed binary lanes of head word
//  out_err    out  1      head word had >=1 invalid input trit
//  err_clr    in   1      clear err_cnt
//  err_cnt    out  CNT_W  saturating count of accepted words with out_err set
// BEHAVIOUR
//  - Accept when in_valid&&in_ready; pop when out_valid&&out_ready. The transform is applied before storage; each FIFO entry holds {err,bin,trit}.
//  - Per-trit map (logic value in->out):
//      STI: 0->2, 1->1, 2->0
//      PTI: 0->2, 1->2, 2->0
//      NTI: 0->2, 1->0, 2->0
//      PASS: unchanged
//    Invalid 2'b00 -> 2'b00 in all modes, and it sets the word's err bit.
//  - Binary lanes: bitwise NOT in modes 0-2; unchanged in PASS.
//  - Latency: word accepted at edge k is at head with out_valid=1 after that edge when the FIFO was empty (1 cycle). There is no combinational in->out path.
//  - Head outputs are driven from registered storage. While out_valid=0, out_trit/out_bin/out_err read 0.
//  - Full: in_ready=0, and in_valid is ignored. Empty: out_valid=0, and out_ready is ignored.
//  - Push and pop in the same cycle (not full, not empty): both occur, and the count is unchanged.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is a separate count of 0..DEPTH.
//  - Held input: a word presented while in_ready=0 stays pending. Producer must hold in_* stable until accepted. The block never drops or duplicates words.
//  - err_cnt: +1 per accepted word with err, saturates at 2^CNT_W-1.
//    err_clr wins over saturation. err_clr with a simultaneous erroneous accept gives err_cnt=1; err_clr alone gives 0.
//  - Reset (sync, any cycle incl. mid-stream): pointers/count=0, out_valid=0, err_cnt=0, head outputs 0. in_ready=0 during rst, 1 in the first cycle after.
//    Words in flight are discarded. Storage contents need no reset.
// TESTING
//  1 Reset then one word N=4 in_trit=8'b10_11_01_00, mode STI, in_bin=1 -> next cycle out_valid=1, out_trit=8'b01_11_10_00, out_bin=0, out_err=1, err_cnt=1.
//  2 Same trits with valid codes 8'b10_11_01_11 in PTI, then NTI, then PASS -> 8'b01_10_10_10, 8'b01_01_10_01, 8'b10_11_01_11. out_err=0 throughout.
//  3 out_ready=0, push DEPTH+2 words -> in_ready drops after DEPTH accepts; then drain -> exactly DEPTH words in order, no loss or duplication; then the 2 held words are accepted.
//  4 Continuous push+pop at full rate for 3*DEPTH words (pointer wrap) -> output order and values match a reference model, and occupancy stays constant.
//  5 CNT_W=2: 5 erroneous words -> err_cnt 1,2,3,3,3. Then err_clr coinciding with an erroneous accept -> err_cnt=1.
//  6 Assert rst with 3 words buffered -> next cycle out_valid=0, err_cnt=0; first word pushed after reset is the first word out.

Source files
------------

// File: rtl/ter_inv_stream.sv
// Streaming ternary inverter for binary-encoded-ternary buses: STI/PTI/NTI/PASS per word,
// results buffered in a DEPTH-entry FIFO with valid/ready on both sides and a saturating error counter.
module ter_inv_stream #(
    parameter int N     = 4,
    parameter int BW    = 1,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*N-1:0]     in_trit,
    input  logic [BW-1:0]      in_bin,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*N-1:0]     out_trit,
    output logic [BW-1:0]      out_bin,
    output logic               out_err,
    input  logic               err_clr,
    output logic [CNT_W-1:0]   err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int W  = 1 + BW + 2*N;

    localparam logic [AW-1:0]    PTR_ONE   = 1;
    localparam logic [AW:0]      CNT_ONE   = 1;
    localparam logic [AW:0]      DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] ERR_ONE   = 1;

    typedef enum logic [1:0] {
        MODE_STI  = 2'd0,
        MODE_PTI  = 2'd1,
        MODE_NTI  = 2'd2,
        MODE_PASS = 2'd3
    } mode_e;

    // BET codes for logic values 0, 1, 2 and the invalid pattern
    localparam logic [1:0] T0 = 2'b01;
    localparam logic [1:0] T1 = 2'b11;
    localparam logic [1:0] T2 = 2'b10;
    localparam logic [1:0] TX = 2'b00;

    function automatic logic [1:0] map_trit(input logic [1:0] code, input mode_e mode);
        logic [1:0] res;
        res = code;
        if (code != TX && mode != MODE_PASS) begin
            case (code)
                T0:      res = T2;
                T1:      res = (mode == MODE_STI) ? T1 : (mode == MODE_PTI) ? T2 : T0;
                default: res = T0;
            endcase
        end
        return res;
    endfunction

    mode_e              mode;
    logic [2*N-1:0]     xf_trit;
    logic [BW-1:0]      xf_bin;
    logic               xf_err;

    logic [W-1:0]       mem_q [DEPTH];
    logic [W-1:0]       head_word;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               full, empty, push, pop;

    assign mode = mode_e'(in_mode);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        xf_trit = '0;
        xf_err  = 1'b0;
        for (int i = 0; i < N; i++) begin
            xf_trit[2*i +: 2] = map_trit(in_trit[2*i +: 2], mode);
            if (in_trit[2*i +: 2] == TX) xf_err = 1'b1;
        end
        xf_bin = (mode == MODE_PASS) ? in_bin : ~in_bin;
    end

    assign full     = (count_q == DEPTH_CNT);
    assign empty    = (count_q == '0);
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign pop      = out_ready && !empty;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        // Clear beats saturation; an erroneous word accepted in the clear cycle still counts once.
        if (err_clr)
            err_cnt_d = (push && xf_err) ? ERR_ONE : '0;
        else if (push && xf_err && err_cnt_q != '1)
            err_cnt_d = err_cnt_q + ERR_ONE;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q gates every read so stale entries never escape.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {xf_err, xf_bin, xf_trit};
    end

    assign head_word = empty ? '0 : mem_q[rd_ptr_q];
    assign out_valid = !empty;
    assign out_err   = head_word[W-1];
    assign out_bin   = head_word[2*N +: BW];
    assign out_trit  = head_word[2*N-1:0];
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ter_inv_stream.sv
// Directed bench for ter_inv_stream (N=4, BW=1, DEPTH=4, CNT_W=2) with a small queue model
// for FIFO ordering and error counting.
module tb_ter_inv_stream;

    localparam int N     = 4;
    localparam int BW    = 1;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   in_trit;
    logic [BW-1:0]    in_bin;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   out_trit;
    logic [BW-1:0]    out_bin;
    logic             out_err;
    logic             err_clr;
    logic [CNT_W-1:0] err_cnt;

    int pass_cnt = 0;
    int total    = 0;

    logic [9:0] q[$];
    int         exp_err = 0;

    ter_inv_stream #(.N(N), .BW(BW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_trit(in_trit), .in_bin(in_bin), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_trit(out_trit), .out_bin(out_bin), .out_err(out_err),
        .err_clr(err_clr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference transform by value tables: rows are modes STI/PTI/NTI, columns input value 0..2.
    function automatic logic [9:0] ref_word(input logic [7:0] t, input logic b, input logic [1:0] m);
        int         tbl [3][3] = '{'{2, 1, 0}, '{2, 2, 0}, '{2, 0, 0}};
        logic [1:0] enc [3]    = '{2'b01, 2'b11, 2'b10};
        logic [7:0] o;
        logic       e;
        int         v;
        o = '0;
        e = 1'b0;
        for (int i = 0; i < 4; i++) begin
            case (t[2*i +: 2])
                2'b01:   v = 0;
                2'b11:   v = 1;
                2'b10:   v = 2;
                default: v = -1;
            endcase
            if (v < 0) e = 1'b1;
            else o[2*i +: 2] = (m == 2'd3) ? enc[v] : enc[tbl[m][v]];
        end
        return {e, (m == 2'd3) ? b : ~b, o};
    endfunction

    // One clock of model-checked operation: compare outputs, then advance DUT and model together.
    task automatic cycle(output bit acc);
        logic [9:0] w;
        bit         push, pop;
        #1;
        check("in_ready", in_ready, q.size() < DEPTH);
        check("out_valid", out_valid, q.size() != 0);
        check("head", {out_err, out_bin, out_trit}, (q.size() != 0) ? q[0] : 10'd0);
        check("err_cnt", err_cnt, exp_err);
        w    = ref_word(in_trit, in_bin, in_mode);
        push = in_valid && (q.size() < DEPTH);
        pop  = out_ready && (q.size() != 0);
        tick();
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(w);
        if (err_clr)                     exp_err = (push && w[9]) ? 1 : 0;
        else if (push && w[9] && exp_err != 3) exp_err++;
        acc = push;
    endtask

    task automatic push_word(input logic [7:0] t, input logic b, input logic [1:0] m);
        bit acc = 0;
        in_valid = 1'b1;
        in_trit  = t;
        in_bin   = b;
        in_mode  = m;
        for (int n = 0; n < 20 && !acc; n++) cycle(acc);
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    logic [7:0] w3 [6] = '{8'h5A, 8'hE5, 8'h7B, 8'h9D, 8'hF6, 8'h6E};
    logic [1:0] enc_t [3] = '{2'b01, 2'b11, 2'b10};
    int         exp_sat [5] = '{1, 2, 3, 3, 3};

    initial begin
        bit         acc;
        logic [7:0] rt;

        rst = 1'b1; in_valid = 1'b0; in_trit = '0; in_bin = '0; in_mode = '0;
        out_ready = 1'b0; err_clr = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_err_cnt", err_cnt, 0);
        check("post_rst_out_trit", out_trit, 0);

        // Single STI word with one invalid trit
        in_valid = 1'b1; in_trit = 8'b10_11_01_00; in_bin = 1'b1; in_mode = 2'd0;
        tick();
        in_valid = 1'b0;
        check("t1_out_valid", out_valid, 1);
        check("t1_out_trit", out_trit, 8'b01_11_10_00);
        check("t1_out_bin", out_bin, 0);
        check("t1_out_err", out_err, 1);
        check("t1_err_cnt", err_cnt, 1);
        out_ready = 1'b1;
        tick();
        check("t1_empty", out_valid, 0);
        check("t1_idle_trit", out_trit, 0);
        check("t1_idle_err", out_err, 0);

        // PTI, NTI, PASS back to back with pop in the same cycle
        in_valid = 1'b1; in_trit = 8'b10_11_01_11; in_bin = 1'b1; in_mode = 2'd1;
        tick();
        check("pti_trit", out_trit, 8'b01_10_10_10);
        check("pti_bin", out_bin, 0);
        check("pti_err", out_err, 0);
        in_mode = 2'd2;
        tick();
        check("nti_trit", out_trit, 8'b01_01_10_01);
        check("nti_valid", out_valid, 1);
        check("nti_err", out_err, 0);
        in_mode = 2'd3;
        tick();
        check("pass_trit", out_trit, 8'b10_11_01_11);
        check("pass_bin", out_bin, 1);
        check("pass_err", out_err, 0);
        in_valid = 1'b0;
        tick();
        check("t2_empty", out_valid, 0);
        check("t2_err_cnt", err_cnt, 1);
        exp_err = 1;

        // Fill to full with consumer stalled, hold two words, then drain
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_word(w3[i], i[0], 2'(i));
        in_trit = w3[4]; in_bin = 1'b1; in_mode = 2'd0; in_valid = 1'b1;
        cycle(acc);
        check("held_1", acc, 0);
        cycle(acc);
        check("held_2", acc, 0);
        check("full_in_ready", in_ready, 0);
        out_ready = 1'b1;
        push_word(w3[4], 1'b1, 2'd0);
        push_word(w3[5], 1'b0, 2'd3);
        in_valid = 1'b0;
        repeat (DEPTH + 1) cycle(acc);
        check("t3_drained", out_valid, 0);

        // Steady push+pop at occupancy 2 across several pointer wraps
        out_ready = 1'b0;
        push_word(8'h55, 1'b0, 2'd0);
        push_word(8'hAA, 1'b1, 2'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 3*DEPTH; k++) begin
            rt = '0;
            for (int j = 0; j < 4; j++) rt[2*j +: 2] = enc_t[$urandom_range(2)];
            push_word(rt, 1'($urandom_range(1)), 2'($urandom_range(3)));
            check("t4_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        repeat (3) cycle(acc);

        // Saturating error counter with CNT_W=2, then clear against an erroneous accept
        err_clr = 1'b1;
        cycle(acc);
        err_clr = 1'b0;
        check("clr_alone", err_cnt, 0);
        for (int k = 0; k < 5; k++) begin
            push_word(8'h58, 1'b0, 2'(k % 4));
            check("sat_step", err_cnt, exp_sat[k]);
        end
        err_clr = 1'b1;
        push_word(8'h34, 1'b1, 2'd2);
        err_clr = 1'b0;
        check("clr_with_err", err_cnt, 1);
        in_valid = 1'b0;
        repeat (2) cycle(acc);

        // Reset mid-stream with three buffered words
        out_ready = 1'b0;
        push_word(8'h5A, 1'b0, 2'd0);
        push_word(8'h04, 1'b1, 2'd1);
        push_word(8'hE5, 1'b0, 2'd3);
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_err_cnt", err_cnt, 0);
        check("mid_rst_out_trit", out_trit, 0);
        rst = 1'b0;
        q.delete();
        exp_err = 0;
        #1;
        check("t6_in_ready", in_ready, 1);
        push_word(8'h9D, 1'b1, 2'd2);
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("t6_first_out", out_trit, 8'b01_10_01_10);
        repeat (2) cycle(acc);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
